// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done operand and result bundle between an operand source (master) and the subtractor (slave).
interface serial_subtractor_if #(parameter int WIDTH = sub_pkg::DEF_WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first, one bit per clock.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] result;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             bit_d;
  logic             bit_bo;
  logic [WIDTH-1:0] next_result;

  full_subtractor u_fs (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_bo)
  );

  // Concatenate-then-shift keeps the WIDTH=1 build legal (no empty part-select).
  assign next_result = WIDTH'({bit_d, result} >> 1);

  // The last SHIFT edge writes the result outputs directly, so DONE needs no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ra     <= '0;
      rb     <= '0;
      result <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            ra    <= bus.a;
            rb    <= bus.b;
            brw   <= bus.bin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          ra     <= ra >> 1;
          rb     <= rb >> 1;
          result <= next_result;
          brw    <= bit_bo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            diff_q <= next_result;
            bout_q <= bit_bo;
          end else begin
            busy_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 subtractor against an arithmetic model, plus a WIDTH=1 build.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int tests = 0;
  int failed = 0;

  serial_subtractor_if #(.WIDTH(W)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(W)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  // Reference: unsigned a - b - bin; bit 8 is the borrow (result went negative).
  function automatic logic [8:0] modelSub(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int x;
    x = int'(a) - int'(b) - int'(bin);
    modelSub = {x < 0, 8'(x)};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model tracks edges elapsed since an accepted start; -1 means ready for a new start.
  int         age = -1;
  logic [8:0] pend = '0;
  logic       expBusy = 1'b0;
  logic       expDone = 1'b0;
  logic [7:0] expDiff = '0;
  logic       expBout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age = -1;
      expBusy = 1'b0;
      expDone = 1'b0;
      expDiff = '0;
      expBout = 1'b0;
    end else begin
      if (age < 0) begin
        if (bus8.start) begin
          age = 0;
          pend = modelSub(bus8.a, bus8.b, bus8.bin);
        end
      end else begin
        age++;
        if (age > W) age = -1;
      end
      expBusy = (age >= 1) && (age <= W - 1);
      expDone = (age == W);
      if (age == W) {expBout, expDiff} = pend;
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", {7'd0, bus8.busy}, {7'd0, expBusy});
    checkOutput("done", {7'd0, bus8.done}, {7'd0, expDone});
    checkOutput("diff", bus8.diff, expDiff);
    checkOutput("bout", {7'd0, bus8.bout}, {7'd0, expBout});
  end

  int busy1Cnt = 0;
  int done1Cnt = 0;
  always @(negedge clk) begin
    if (bus1.busy) busy1Cnt++;
    if (bus1.done) done1Cnt++;
  end

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (age < 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("idleTimeout", 8'd0, 8'd1);
  endtask

  task automatic waitDone(output bit found);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("doneTimeout", 8'd0, 8'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                               input logic [7:0] litDiff, input logic litBout);
    logic [8:0] m;
    int lat;
    bit found;
    waitIdle();
    m = modelSub(a, b, bin);
    checkOutput("modelDiff", m[7:0], litDiff);
    checkOutput("modelBout", {7'd0, m[8]}, {7'd0, litBout});
    bus8.a = a;
    bus8.b = b;
    bus8.bin = bin;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!found) checkOutput("doneTimeout", 8'd0, 8'd1);
    checkOutput("latency", 8'(lat), 8'(W));
    checkOutput("litDiff", bus8.diff, litDiff);
    checkOutput("litBout", {7'd0, bus8.bout}, {7'd0, litBout});
  endtask

  initial begin
    bit found;
    int gap;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstDiff", bus8.diff, 8'h00);
    checkOutput("rstDone", {7'd0, bus8.done}, 8'h00);
    rst_n = 1'b1;

    applyStimulus(8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    applyStimulus(8'h55, 8'h55, 1'b1, 8'hFF, 1'b1);
    applyStimulus(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    // WIDTH=1 build: 0 - 1 borrows, done one edge after accept.
    @(posedge clk);
    #1;
    bus1.a = 1'b0; bus1.b = 1'b1; bus1.bin = 1'b0; bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    @(negedge clk);
    checkOutput("w1DoneEarly", {7'd0, bus1.done}, 8'd0);
    @(negedge clk);
    checkOutput("w1Done", {7'd0, bus1.done}, 8'd1);
    checkOutput("w1Diff", {7'd0, bus1.diff}, 8'd1);
    checkOutput("w1Bout", {7'd0, bus1.bout}, 8'd1);

    // Start held high, operands changed mid-operation.
    waitIdle();
    bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    bus8.a = 8'hAA; bus8.b = 8'h33;
    waitDone(found);
    checkOutput("holdDiff", bus8.diff, 8'h0F);
    checkOutput("holdBout", {7'd0, bus8.bout}, 8'd0);
    gap = 0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
      if (bus8.done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("holdTimeout", 8'd0, 8'd1);
    checkOutput("holdGap", 8'(gap), 8'(W + 2));
    checkOutput("hold2Diff", bus8.diff, 8'h77);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;

    // Reset in the middle of SHIFT aborts with every output cleared.
    waitIdle();
    bus8.a = 8'hC3; bus8.b = 8'h3C; bus8.bin = 1'b1; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", {7'd0, bus8.busy}, 8'd0);
    checkOutput("abortDone", {7'd0, bus8.done}, 8'd0);
    checkOutput("abortDiff", bus8.diff, 8'd0);
    checkOutput("abortBout", {7'd0, bus8.bout}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0);

    // Random traffic: start and operands change every cycle.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      bus8.start = ($urandom_range(0, 3) == 0);
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      bus8.bin = 1'($urandom_range(0, 1));
    end
    waitIdle();
    repeat (2) @(posedge clk);

    checkOutput("w1BusyNever", 8'(busy1Cnt), 8'd0);
    checkOutput("w1DoneCount", 8'(done1Cnt), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
